// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared state encoding, command codes, default geometry and
// helpers for the convolution pass scheduler.
package conv_sched_pkg;

    localparam int KERNEL_SIZE_DEF  = 3;
    localparam int IMAGE_ROWS_DEF   = 8;
    localparam int NUM_FEATURES_DEF = 4;
    localparam int MAC_LATENCY_DEF  = 2;

    function automatic int taps_of(input int k);
        return k * k;
    endfunction

    function automatic int out_rows_of(input int rows, input int k);
        return rows - k + 1;
    endfunction

    localparam int TAPS     = taps_of(KERNEL_SIZE_DEF);
    localparam int OUT_ROWS = out_rows_of(IMAGE_ROWS_DEF, KERNEL_SIZE_DEF);

    localparam logic [1:0] CMD_NOP          = 2'b00;
    localparam logic [1:0] CMD_FETCH_TAP    = 2'b01;
    localparam logic [1:0] CMD_LOAD_FEATURE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_FETCH  = 3'd3,
        ST_ACCUM  = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_OUTPUT = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    // Saturating 32-bit increment used by the performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/conv_sched_counters.sv
// conv_sched_counters: nested tap / row / feature counters with last-flags.
// The scheduler FSM only issues clear and increment requests; wrap points are
// compared against parameter-derived limits rather than natural overflow.
module conv_sched_counters #(
    parameter int TAPS         = 9,
    parameter int OUT_ROWS     = 6,
    parameter int NUM_FEATURES = 4,
    parameter int TAP_W        = 4,
    parameter int ROW_W        = 3,
    parameter int IDX_W        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_all,
    input  logic             tap_clr,
    input  logic             tap_inc,
    input  logic             row_adv,
    output logic [TAP_W-1:0] tap_cnt,
    output logic [ROW_W-1:0] row_cnt,
    output logic [IDX_W-1:0] feat_cnt,
    output logic             tap_last,
    output logic             row_last,
    output logic             feat_last
);

    logic [TAP_W-1:0] tap_cnt_q,  tap_cnt_d;
    logic [ROW_W-1:0] row_cnt_q,  row_cnt_d;
    logic [IDX_W-1:0] feat_cnt_q, feat_cnt_d;

    assign tap_last  = (tap_cnt_q  == TAP_W'(TAPS - 1));
    assign row_last  = (row_cnt_q  == ROW_W'(OUT_ROWS - 1));
    assign feat_last = (feat_cnt_q == IDX_W'(NUM_FEATURES - 1));

    assign tap_cnt  = tap_cnt_q;
    assign row_cnt  = row_cnt_q;
    assign feat_cnt = feat_cnt_q;

    // Next-count logic: row advance wraps into the feature counter.
    always_comb begin
        tap_cnt_d  = tap_cnt_q;
        row_cnt_d  = row_cnt_q;
        feat_cnt_d = feat_cnt_q;
        if (clr_all) begin
            tap_cnt_d  = '0;
            row_cnt_d  = '0;
            feat_cnt_d = '0;
        end else begin
            if (tap_clr) begin
                tap_cnt_d = '0;
            end else if (tap_inc) begin
                tap_cnt_d = tap_cnt_q + TAP_W'(1);
            end
            if (row_adv) begin
                if (row_last) begin
                    row_cnt_d  = '0;
                    feat_cnt_d = feat_last ? '0 : feat_cnt_q + IDX_W'(1);
                end else begin
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                end
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt_q  <= '0;
            row_cnt_q  <= '0;
            feat_cnt_q <= '0;
        end else begin
            tap_cnt_q  <= tap_cnt_d;
            row_cnt_q  <= row_cnt_d;
            feat_cnt_q <= feat_cnt_d;
        end
    end

endmodule

// File: rtl/conv_pass_scheduler.sv
// conv_pass_scheduler: sequences one convolution pass of the kernel array.
// Issues LOAD_FEATURE / FETCH_TAP commands, strobes clear/accumulate into the
// kernel array, waits out the MAC latency and publishes each row with
// back-pressure. Optional macro CONV_SCHED_PERF_CNT_EN adds busy/stall
// cycle counters.
module conv_pass_scheduler
    import conv_sched_pkg::*;
#(
    parameter int KERNEL_SIZE  = KERNEL_SIZE_DEF,
    parameter int IMAGE_ROWS   = IMAGE_ROWS_DEF,
    parameter int NUM_FEATURES = NUM_FEATURES_DEF,
    parameter int MAC_LATENCY  = MAC_LATENCY_DEF,
    parameter int IDX_W        = 2,
    parameter int ROW_W        = 3,
    parameter int TAP_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [1:0]       input_interface_cmd,
    input  logic [1:0]       input_interface_ack,
    output logic [TAP_W-1:0] tap_idx,
    output logic             kernel_array_clear,
    output logic             kernel_accum_en,
    output logic             kernel_calc_fin,
    input  logic             out_ready,
    output logic [IDX_W-1:0] feature_idx,
    output logic [ROW_W-1:0] feature_row,
    output logic             busy,
    output logic             pass_done
`ifdef CONV_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]      busy_cycles,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int N_TAPS   = taps_of(KERNEL_SIZE);
    localparam int N_ROWS   = out_rows_of(IMAGE_ROWS, KERNEL_SIZE);
    localparam int DRAIN_W  = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    state_t             state_q, state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

    logic             clr_all, tap_clr, tap_inc, row_adv;
    logic [TAP_W-1:0] tap_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [IDX_W-1:0] feat_cnt;
    logic             tap_last, row_last, feat_last;

    conv_sched_counters #(
        .TAPS         (N_TAPS),
        .OUT_ROWS     (N_ROWS),
        .NUM_FEATURES (NUM_FEATURES),
        .TAP_W        (TAP_W),
        .ROW_W        (ROW_W),
        .IDX_W        (IDX_W)
    ) u_counters (
        .clk       (clk),
        .rst       (rst),
        .clr_all   (clr_all),
        .tap_clr   (tap_clr),
        .tap_inc   (tap_inc),
        .row_adv   (row_adv),
        .tap_cnt   (tap_cnt),
        .row_cnt   (row_cnt),
        .feat_cnt  (feat_cnt),
        .tap_last  (tap_last),
        .row_last  (row_last),
        .feat_last (feat_last)
    );

    // Next-state, counter requests and state-decoded outputs; abort overrides
    // everything outside IDLE so the pass dies cleanly in one cycle.
    always_comb begin
        state_d             = state_q;
        drain_cnt_d         = drain_cnt_q;
        clr_all             = 1'b0;
        tap_clr             = 1'b0;
        tap_inc             = 1'b0;
        row_adv             = 1'b0;
        input_interface_cmd = CMD_NOP;
        tap_idx             = '0;
        kernel_array_clear  = 1'b0;
        kernel_accum_en     = 1'b0;
        kernel_calc_fin     = 1'b0;
        pass_done           = 1'b0;
        busy                = (state_q != ST_IDLE);
        feature_idx         = feat_cnt;
        feature_row         = row_cnt;

        unique case (state_q)
            ST_IDLE: ;
            ST_LOAD:   input_interface_cmd = CMD_LOAD_FEATURE;
            ST_CLEAR:  kernel_array_clear  = 1'b1;
            ST_FETCH: begin
                input_interface_cmd = CMD_FETCH_TAP;
                tap_idx             = tap_cnt;
            end
            ST_ACCUM:  kernel_accum_en = 1'b1;
            ST_DRAIN: ;
            ST_OUTPUT: kernel_calc_fin = 1'b1;
            ST_DONE:   pass_done = 1'b1;
            default: ;
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            drain_cnt_d = '0;
            clr_all     = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_d = ST_LOAD;
                        clr_all = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (input_interface_ack == CMD_LOAD_FEATURE) state_d = ST_CLEAR;
                end
                ST_CLEAR: begin
                    tap_clr = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (input_interface_ack == CMD_FETCH_TAP) state_d = ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (tap_last) begin
                        drain_cnt_d = '0;
                        state_d     = ST_DRAIN;
                    end else begin
                        tap_inc = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == DRAIN_W'(MAC_LATENCY - 1)) begin
                        state_d = ST_OUTPUT;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        if (row_last && feat_last) begin
                            clr_all = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            row_adv = 1'b1;
                            state_d = row_last ? ST_LOAD : ST_CLEAR;
                        end
                    end
                end
                ST_DONE:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // State and drain-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

`ifdef CONV_SCHED_PERF_CNT_EN
    logic [31:0] busy_cycles_q,  busy_cycles_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic        stall_now;

    assign busy_cycles  = busy_cycles_q;
    assign stall_cycles = stall_cycles_q;

    // Busy/stall accounting; both restart when a new pass is accepted.
    always_comb begin
        busy_cycles_d  = busy_cycles_q;
        stall_cycles_d = stall_cycles_q;
        stall_now = ((state_q == ST_FETCH)  && (input_interface_ack != CMD_FETCH_TAP))    ||
                    ((state_q == ST_LOAD)   && (input_interface_ack != CMD_LOAD_FEATURE)) ||
                    ((state_q == ST_OUTPUT) && !out_ready);
        if ((state_q == ST_IDLE) && start && !abort) begin
            busy_cycles_d  = '0;
            stall_cycles_d = '0;
        end else begin
            if (state_q != ST_IDLE) busy_cycles_d  = sat_inc32(busy_cycles_q);
            if (stall_now)          stall_cycles_d = sat_inc32(stall_cycles_q);
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cycles_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            busy_cycles_q  <= busy_cycles_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end
`endif

endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Testbench for conv_pass_scheduler: scoreboard of expected output rows
// (feature, row, accumulate count, latency, hold cycles, tap-4 fetch cycles).
module tb_conv_pass_scheduler;
    import conv_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] input_interface_cmd;
    logic [1:0] input_interface_ack = 2'b00;
    logic [3:0] tap_idx;
    logic       kernel_array_clear, kernel_accum_en, kernel_calc_fin;
    logic       out_ready = 1'b1;
    logic [1:0] feature_idx;
    logic [2:0] feature_row;
    logic       busy, pass_done;
`ifdef CONV_SCHED_PERF_CNT_EN
    logic [31:0] busy_cycles, stall_cycles;
`endif

    conv_pass_scheduler dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .abort               (abort),
        .input_interface_cmd (input_interface_cmd),
        .input_interface_ack (input_interface_ack),
        .tap_idx             (tap_idx),
        .kernel_array_clear  (kernel_array_clear),
        .kernel_accum_en     (kernel_accum_en),
        .kernel_calc_fin     (kernel_calc_fin),
        .out_ready           (out_ready),
        .feature_idx         (feature_idx),
        .feature_row         (feature_row),
        .busy                (busy),
        .pass_done           (pass_done)
`ifdef CONV_SCHED_PERF_CNT_EN
        ,
        .busy_cycles         (busy_cycles),
        .stall_cycles        (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int feat; int row; int acc; int lat; int fin; int t4;
    } row_t;

    row_t exp_q[$];
    row_t obs_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pd_cnt = 0;
    int   cmd_bad = 0;
    int   cur_acc = 0, cur_lat = 0, cur_fin = 0, cur_t4 = 0;
    bit   fin_seen = 1'b0;

    bit   delay_en = 1'b0, spur_en = 1'b0, stall_en = 1'b0;
    int   wcnt = 0, scnt = 0;

    // Input-interface responder and downstream consumer.
    initial begin
        forever begin
            int want;
            logic [1:0] a;
            @(posedge clk);
            #1;
            a = 2'b00;
            if (input_interface_cmd != 2'b00) begin
                want = 0;
                if (delay_en && input_interface_cmd == 2'b01 && tap_idx == 4 &&
                    feature_idx == 0 && feature_row == 0) want = 3;
                if (spur_en && input_interface_cmd == 2'b01) want = 1;
                if (wcnt >= want) begin
                    a = input_interface_cmd;
                    wcnt = 0;
                end else begin
                    a = (spur_en && input_interface_cmd == 2'b01) ? 2'b10 : 2'b00;
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                if (spur_en && kernel_array_clear) a = 2'b01;
            end
            input_interface_ack = a;
            if (stall_en && kernel_calc_fin && feature_idx == 1 && feature_row == 2 && scnt < 5) begin
                out_ready = 1'b0;
                scnt++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: builds one observation record per accepted row.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                cur_acc = 0; cur_lat = 0; cur_fin = 0; cur_t4 = 0; fin_seen = 1'b0;
            end else begin
                if (kernel_array_clear) begin
                    cur_lat = 1; cur_acc = 0; cur_fin = 0; cur_t4 = 0; fin_seen = 1'b0;
                end else if (!fin_seen) begin
                    cur_lat++;
                end
                if (kernel_accum_en) cur_acc++;
                if (input_interface_cmd == 2'b01 && tap_idx == 4) cur_t4++;
                if (kernel_calc_fin) begin
                    fin_seen = 1'b1;
                    cur_fin++;
                    if (input_interface_cmd != 2'b00) cmd_bad++;
                    if (out_ready)
                        obs_q.push_back('{int'(feature_idx), int'(feature_row), cur_acc, cur_lat, cur_fin, cur_t4});
                end
                if (pass_done) pd_cnt++;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({input_interface_cmd, tap_idx, kernel_array_clear, kernel_accum_en, kernel_calc_fin,
             feature_idx, feature_row, busy, pass_done} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got cmd=%b tap=%0d busy=%b fin=%b, want all zero",
                     input_interface_cmd, tap_idx, busy, kernel_calc_fin);
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if ({input_interface_cmd, busy, kernel_calc_fin, pass_done} !== 5'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got cmd=%b busy=%b, want 00/0", input_interface_cmd, busy);
        end
    endtask

    task automatic test_full_pass();
        int pd0;
        row_t e, o;
        for (int f = 0; f < NUM_FEATURES_DEF; f++)
            for (int r = 0; r < OUT_ROWS; r++) exp_q.push_back('{f, r, TAPS, 22, 1, 1});
        pd0 = pd_cnt;
        pulse_start();
        repeat (50) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        for (int i = 0; i < 4000; i++) begin @(posedge clk); if (pd_cnt != pd0) break; end
        repeat (5) @(posedge clk);
        #2;
        n_cmp++;
        if (pd_cnt !== pd0 + 1) begin
            n_bad++; $display("FAIL full_pass_done: got %0d pulses, want 1", pd_cnt - pd0);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL full_pass_busy: got %b want 0", busy); end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL full_pass_rows: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o.feat !== e.feat || o.row !== e.row || o.acc !== e.acc || o.lat !== e.lat || o.fin !== e.fin || o.t4 !== e.t4) begin
                n_bad++;
                $display("FAIL full_pass_row: got f%0d r%0d acc%0d lat%0d fin%0d t4_%0d want f%0d r%0d acc%0d lat%0d fin%0d t4_%0d",
                         o.feat, o.row, o.acc, o.lat, o.fin, o.t4, e.feat, e.row, e.acc, e.lat, e.fin, e.t4);
            end
        end
        exp_q.delete(); obs_q.delete();
`ifdef CONV_SCHED_PERF_CNT_EN
        n_cmp++;
        if (busy_cycles !== 32'(24 * 22 + 4 + 1) || stall_cycles !== 32'd0) begin
            n_bad++; $display("FAIL full_pass_perf: got busy=%0d stall=%0d want 533/0", busy_cycles, stall_cycles);
        end
`endif
    endtask

    task automatic test_ack_delay();
        int pd0;
        row_t e, o;
        for (int f = 0; f < NUM_FEATURES_DEF; f++)
            for (int r = 0; r < OUT_ROWS; r++)
                exp_q.push_back('{f, r, TAPS, (f == 0 && r == 0) ? 25 : 22, 1, (f == 0 && r == 0) ? 4 : 1});
        delay_en = 1'b1;
        pd0 = pd_cnt;
        pulse_start();
        for (int i = 0; i < 4000; i++) begin @(posedge clk); if (pd_cnt != pd0) break; end
        repeat (3) @(posedge clk);
        delay_en = 1'b0;
        n_cmp++;
        if (pd_cnt !== pd0 + 1) begin
            n_bad++; $display("FAIL ack_delay_done: got %0d pulses, want 1", pd_cnt - pd0);
        end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL ack_delay_rows: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o.feat !== e.feat || o.row !== e.row || o.acc !== e.acc || o.lat !== e.lat || o.fin !== e.fin || o.t4 !== e.t4) begin
                n_bad++;
                $display("FAIL ack_delay_row: got f%0d r%0d acc%0d lat%0d fin%0d t4_%0d want f%0d r%0d acc%0d lat%0d fin%0d t4_%0d",
                         o.feat, o.row, o.acc, o.lat, o.fin, o.t4, e.feat, e.row, e.acc, e.lat, e.fin, e.t4);
            end
        end
        exp_q.delete(); obs_q.delete();
`ifdef CONV_SCHED_PERF_CNT_EN
        n_cmp++;
        if (busy_cycles !== 32'd536 || stall_cycles !== 32'd3) begin
            n_bad++; $display("FAIL ack_delay_perf: got busy=%0d stall=%0d want 536/3", busy_cycles, stall_cycles);
        end
`endif
    endtask

    task automatic test_backpressure();
        int pd0;
        row_t e, o;
        for (int f = 0; f < NUM_FEATURES_DEF; f++)
            for (int r = 0; r < OUT_ROWS; r++)
                exp_q.push_back('{f, r, TAPS, 22, (f == 1 && r == 2) ? 6 : 1, 1});
        stall_en = 1'b1; scnt = 0; cmd_bad = 0;
        pd0 = pd_cnt;
        pulse_start();
        for (int i = 0; i < 4000; i++) begin @(posedge clk); if (pd_cnt != pd0) break; end
        repeat (3) @(posedge clk);
        stall_en = 1'b0;
        n_cmp++;
        if (pd_cnt !== pd0 + 1) begin
            n_bad++; $display("FAIL backpressure_done: got %0d pulses, want 1", pd_cnt - pd0);
        end
        n_cmp++;
        if (cmd_bad !== 0) begin
            n_bad++; $display("FAIL backpressure_cmd: got %0d cmd cycles during output, want 0", cmd_bad);
        end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL backpressure_rows: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o.feat !== e.feat || o.row !== e.row || o.acc !== e.acc || o.lat !== e.lat || o.fin !== e.fin || o.t4 !== e.t4) begin
                n_bad++;
                $display("FAIL backpressure_row: got f%0d r%0d acc%0d lat%0d fin%0d t4_%0d want f%0d r%0d acc%0d lat%0d fin%0d t4_%0d",
                         o.feat, o.row, o.acc, o.lat, o.fin, o.t4, e.feat, e.row, e.acc, e.lat, e.fin, e.t4);
            end
        end
        exp_q.delete(); obs_q.delete();
`ifdef CONV_SCHED_PERF_CNT_EN
        n_cmp++;
        if (busy_cycles !== 32'd538 || stall_cycles !== 32'd5) begin
            n_bad++; $display("FAIL backpressure_perf: got busy=%0d stall=%0d want 538/5", busy_cycles, stall_cycles);
        end
`endif
    endtask

    task automatic test_spurious_ack();
        int pd0;
        row_t e, o;
        for (int f = 0; f < NUM_FEATURES_DEF; f++)
            for (int r = 0; r < OUT_ROWS; r++) exp_q.push_back('{f, r, TAPS, 31, 1, 2});
        spur_en = 1'b1;
        pd0 = pd_cnt;
        pulse_start();
        for (int i = 0; i < 4000; i++) begin @(posedge clk); if (pd_cnt != pd0) break; end
        repeat (3) @(posedge clk);
        spur_en = 1'b0;
        n_cmp++;
        if (pd_cnt !== pd0 + 1) begin
            n_bad++; $display("FAIL spurious_done: got %0d pulses, want 1", pd_cnt - pd0);
        end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL spurious_rows: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o.feat !== e.feat || o.row !== e.row || o.acc !== e.acc || o.lat !== e.lat || o.fin !== e.fin || o.t4 !== e.t4) begin
                n_bad++;
                $display("FAIL spurious_row: got f%0d r%0d acc%0d lat%0d fin%0d t4_%0d want f%0d r%0d acc%0d lat%0d fin%0d t4_%0d",
                         o.feat, o.row, o.acc, o.lat, o.fin, o.t4, e.feat, e.row, e.acc, e.lat, e.fin, e.t4);
            end
        end
        exp_q.delete(); obs_q.delete();
`ifdef CONV_SCHED_PERF_CNT_EN
        n_cmp++;
        if (busy_cycles !== 32'(24 * 31 + 4 + 1) || stall_cycles !== 32'(24 * 9)) begin
            n_bad++; $display("FAIL spurious_perf: got busy=%0d stall=%0d want 749/216", busy_cycles, stall_cycles);
        end
`endif
    endtask

    task automatic test_abort();
        int pd0;
        bit hit;
        row_t e, o;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < OUT_ROWS; r++) exp_q.push_back('{f, r, TAPS, 22, 1, 1});
        for (int r = 0; r < 3; r++) exp_q.push_back('{2, r, TAPS, 22, 1, 1});
        pd0 = pd_cnt;
        hit = 1'b0;
        pulse_start();
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #2;
            if (input_interface_cmd == 2'b01 && tap_idx == 7 && feature_idx == 2 && feature_row == 3) begin
                hit = 1'b1; break;
            end
        end
        n_cmp++;
        if (!hit) begin n_bad++; $display("FAIL abort_reach: got timeout, want FETCH (2,3) tap 7"); end
        abort = 1'b1;
        @(posedge clk); #2;
        n_cmp++;
        if ({busy, input_interface_cmd, kernel_calc_fin, kernel_accum_en, feature_idx, feature_row} !== 10'b0) begin
            n_bad++;
            $display("FAIL abort_state: got busy=%b cmd=%b idx=%0d row=%0d, want all zero",
                     busy, input_interface_cmd, feature_idx, feature_row);
        end
        abort = 1'b0;
        repeat (5) @(posedge clk);
        n_cmp++;
        if (pd_cnt !== pd0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", pd_cnt - pd0); end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL abort_rows: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o.feat !== e.feat || o.row !== e.row || o.acc !== e.acc) begin
                n_bad++;
                $display("FAIL abort_row: got f%0d r%0d acc%0d want f%0d r%0d acc%0d", o.feat, o.row, o.acc, e.feat, e.row, e.acc);
            end
        end
        exp_q.delete(); obs_q.delete();
        for (int f = 0; f < NUM_FEATURES_DEF; f++)
            for (int r = 0; r < OUT_ROWS; r++) exp_q.push_back('{f, r, TAPS, 22, 1, 1});
        pd0 = pd_cnt;
        pulse_start();
        for (int i = 0; i < 4000; i++) begin @(posedge clk); if (pd_cnt != pd0) break; end
        repeat (3) @(posedge clk);
        n_cmp++;
        if (pd_cnt !== pd0 + 1) begin n_bad++; $display("FAIL restart_done: got %0d pulses want 1", pd_cnt - pd0); end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL restart_rows: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++;
            if (o.feat !== e.feat || o.row !== e.row || o.acc !== e.acc || o.lat !== e.lat || o.fin !== e.fin) begin
                n_bad++;
                $display("FAIL restart_row: got f%0d r%0d acc%0d lat%0d fin%0d want f%0d r%0d acc%0d lat%0d fin%0d",
                         o.feat, o.row, o.acc, o.lat, o.fin, e.feat, e.row, e.acc, e.lat, e.fin);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_start_abort();
        int busy_seen;
        @(posedge clk); #2 start = 1'b1; abort = 1'b1;
        @(posedge clk); #2 start = 1'b0; abort = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy || input_interface_cmd != 2'b00) busy_seen++;
            @(posedge clk); #2;
        end
        n_cmp++;
        if (busy_seen !== 0) begin
            n_bad++; $display("FAIL start_abort: got %0d busy cycles, want 0", busy_seen);
        end
    endtask

    task automatic test_async_reset();
        int pd0, act;
        bit hit;
        pd0 = pd_cnt;
        hit = 1'b0;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (busy && !kernel_accum_en && !kernel_array_clear && !kernel_calc_fin &&
                input_interface_cmd == 2'b00 && cur_acc == 9) begin
                hit = 1'b1; break;
            end
        end
        n_cmp++;
        if (!hit) begin n_bad++; $display("FAIL rst_reach_drain: got timeout, want DRAIN"); end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, input_interface_cmd, kernel_calc_fin, kernel_accum_en, kernel_array_clear,
             pass_done, feature_idx, feature_row, tap_idx} !== 17'b0) begin
            n_bad++; $display("FAIL rst_async: got busy=%b cmd=%b fin=%b, want all zero", busy, input_interface_cmd, kernel_calc_fin);
        end
        #3 rst = 1'b0;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (busy || kernel_calc_fin || kernel_array_clear || kernel_accum_en || input_interface_cmd != 2'b00) act++;
        end
        n_cmp++;
        if (act !== 0 || pd_cnt !== pd0) begin
            n_bad++; $display("FAIL rst_release: got %0d active cycles, %0d done pulses, want 0/0", act, pd_cnt - pd0);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_ack_delay();
        test_backpressure();
        test_spurious_ack();
        test_abort();
        test_start_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_pass_scheduler.md
Name: conv_pass_scheduler

Overview:
- Sequences one full convolution pass of the 3x3 kernel array over the input image.
- Issues fetch commands to the conv-layer input interface and handshakes on its ack. Drives clear and accumulate strobes into the kernel array.
- Publishes each finished output row with its feature index and row number to the downstream consumer, with back-pressure.
- Sits between the layer-level start/abort control and the input interface / kernel array pair.

Parameters:
- KERNEL_SIZE, 3, kernel edge; taps per row = KERNEL_SIZE*KERNEL_SIZE.
- IMAGE_ROWS, 8, input image rows; output rows OUT_ROWS = IMAGE_ROWS-KERNEL_SIZE+1 (6).
- NUM_FEATURES, 4, feature maps per pass.
- MAC_LATENCY, 2, cycles from last accumulate strobe until the array output is valid.
- IDX_W, 2, feature_idx width; ROW_W, 3, feature_row width; TAP_W, 4, tap counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a pass when idle.
- abort  in  1  level; terminates a pass.
- input_interface_cmd  out  2  00 NOP, 01 FETCH_TAP, 10 LOAD_FEATURE, 11 reserved.
- input_interface_ack  in  2  echoes the completed cmd for one cycle; 00 otherwise.
- tap_idx  out  TAP_W  current tap, valid while cmd!=NOP.
- kernel_array_clear  out  1  one-cycle accumulator clear.
- kernel_accum_en  out  1  one-cycle accumulate strobe.
- kernel_calc_fin  out  1  row result valid (held until out_ready).
- out_ready  in  1  downstream accepts the row.
- feature_idx  out  IDX_W  feature map of the current row.
- feature_row  out  ROW_W  output row number.
- busy  out  1  high whenever state!=IDLE.
- pass_done  out  1  one-cycle pulse after the last row is accepted.

Interface decision, already fixed: one clock; reset is asynchronous and active-high; ports named clk and rst.

Behaviour:
- Reset values: all outputs 0; cmd NOP; counters 0; state IDLE.
- States and transitions:
  - IDLE: start -> LOAD.
  - LOAD: cmd=LOAD_FEATURE, held; ack==10 -> CLEAR.
  - CLEAR: kernel_array_clear=1 for one cycle; tap_cnt=0 -> FETCH.
  - FETCH: cmd=FETCH_TAP and tap_idx=tap_cnt, both held; ack==01 -> ACCUM.
  - ACCUM: kernel_accum_en=1 for one cycle.
    - If tap_cnt==K*K-1 -> DRAIN with drain_cnt=0.
    - Else tap_cnt++ -> FETCH.
  - DRAIN: wait MAC_LATENCY cycles -> OUTPUT.
  - OUTPUT: kernel_calc_fin=1; feature_idx and feature_row stable; exit on out_ready.
    - Row and feature not both last: advance row_cnt, or wrap row_cnt to 0 and feat_cnt++ -> LOAD on a feature change, CLEAR otherwise.
    - Last row of last feature -> DONE.
  - DONE: pass_done=1 for one cycle -> IDLE.
- Handshake rules:
  - cmd holds its value until a matching ack.
  - An ack that does not match the current cmd, or arrives in any other state, is ignored.
  - cmd returns to NOP in the cycle after the matching ack.
- Output-row latency with zero-wait ack:
  - 1 (clear) + K*K*(1 fetch + 1 accum) + MAC_LATENCY + 1 = 22 cycles for K=3.
  - Each cycle of ack wait adds one cycle.
- Counter widths: counters are sized by IDX_W/ROW_W/TAP_W. Compare against parameter-derived constants, never rely on natural overflow.
- start while busy: ignored.
- start coincident with abort: abort wins; stay IDLE.
- abort in any non-IDLE state:
  - Next cycle: IDLE, cmd NOP, strobes 0, kernel_calc_fin 0, counters 0.
  - No pass_done.
- out_ready held high entering OUTPUT: row accepted in its first cycle (kernel_calc_fin high exactly 1 cycle).
- Async rst mid-pass: immediate return to reset values; no partial pulse on release.

Optional Feature:
- Macro CONV_SCHED_PERF_CNT_EN.
- Defined: adds a 32-bit busy_cycles output (counts cycles with busy=1) and a 32-bit stall_cycles output (counts cycles in FETCH/LOAD awaiting ack plus OUTPUT with out_ready=0).
  - Both counters clear on start accepted and saturate at all-ones.
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package conv_sched_pkg:
  - state enum.
  - cmd encodings CMD_NOP/CMD_FETCH_TAP/CMD_LOAD_FEATURE.
  - derived constants OUT_ROWS and TAPS.
- One natural sub-module, conv_sched_counters: the nested tap/row/feature counters with last-flags; the FSM only issues inc/clear.

Test Plan:
- Reset then start, ack returned 1 cycle after each cmd, out_ready=1:
  - 24 kernel_calc_fin pulses, feature_idx 0..3 by feature_row 0..5 in order.
  - 9 accum strobes per row; pass_done once.
- Ack delayed 3 cycles on tap 4 of row 0: cmd stays 01 with tap_idx=4 for 4 cycles; row 0 latency = 25 cycles.
- out_ready low for 5 cycles at row (1,2): kernel_calc_fin and idx/row held for 6 cycles; no new cmd issued.
- abort asserted during FETCH of row (2,3), tap 7: next cycle busy=0, cmd=00; no pass_done; a following start restarts at (0,0).
- Spurious ack=10 during FETCH and ack=01 during CLEAR: ignored; sequence unchanged.
- rst pulsed mid-DRAIN: outputs 0 asynchronously. With CONV_SCHED_PERF_CNT_EN, busy_cycles after a clean zero-wait pass = 24*22 + 4 + 1.
